sector_buffer_ram: RTL and testbench
====================================

// Module: sector_buffer_ram
// PURPOSE
//  Parametrised synchronous single-port buffer RAM for floppy sector data, with a host
//  random-access port and an auto-incrementing streaming port (valid/ready) for the
//  MFM/FM encoder/decoder path. Sits between the host bus and the disk-side bit engine.
//  Adds reset, split data buses, registered-read handshake, burst streaming with wrap.
// PARAMETERS
//  DATA_W  8    word width, bits
//  ADDR_W  13   address width; depth = 2**ADDR_W words
// PORTS
//  clk        in   1        single clock; all logic on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  cpu_en     in   1        host request; accepted when cpu_en & cpu_ready
//  cpu_rw     in   1        1 = read, 0 = write
//  cpu_addr   in   ADDR_W   host word address
//  cpu_wdata  in   DATA_W   host write data
//  cpu_ready  out  1        host may issue; = (state==IDLE) & !str_start
//  cpu_rdata  out  DATA_W   host read data, held until next host read
//  cpu_rvalid out  1        1-cycle pulse, read data valid
//  str_start  in   1        start burst (sampled in IDLE only)
//  str_dir    in   1        1 = RAM->stream out, 0 = stream in->RAM
//  str_base   in   ADDR_W   first burst address
//  str_len    in   ADDR_W+1 burst length in words (0..2**ADDR_W)
//  str_abort  in   1        terminate burst
//  str_odata/str_ovalid out DATA_W/1; str_oready in 1   outbound stream
//  str_idata/str_ivalid in  DATA_W/1; str_iready out 1  inbound stream
//  str_busy   out  1        burst in progress
//  str_done   out  1        1-cycle pulse after last beat of a burst
//  parity_err out  1        pulse with a read beat whose parity mismatches
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0 except cpu_ready=1; RAM contents not cleared.
//  - Host read: accepted at edge N, cpu_rdata/cpu_rvalid valid after edge N+1 (latency 1).
//  - Host write: RAM updated at the accepting edge; no response pulse.
//  - str_start and cpu_en in same IDLE cycle: stream wins, host request not accepted
//    (cpu_ready low); host holds request until accepted.
//  - FSM: IDLE -> RD_STREAM (str_dir=1) | WR_STREAM (str_dir=0) | DONE (str_len=0);
//    RD/WR_STREAM -> DONE after last beat; DONE -> IDLE (str_done=1 for that cycle).
//  - Address pointer starts at str_base, +1 per beat, wraps modulo 2**ADDR_W.
//  - RD_STREAM: RAM prefetched into 2-entry skid buffer; issue read only if
//    outstanding+buffered < 2; beat = str_ovalid & str_oready; with oready held high,
//    one word per cycle after 1-cycle initial latency; str_odata stable while stalled.
//  - WR_STREAM: str_iready=1 while words remain; beat = str_ivalid & str_iready
//    writes str_idata at pointer in that cycle.
//  - Beat counter counts to str_len exactly; str_len = 2**ADDR_W covers whole array.
//  - str_abort in RD/WR_STREAM: next cycle IDLE, skid buffer flushed, in-flight read
//    discarded, str_ovalid/str_iready drop, no str_done. In IDLE/DONE: ignored.
//  - str_start while busy: ignored. rst_n low mid-burst: immediate IDLE, outputs reset.
// CONFIGURATION
//  - SECTOR_RAM_PARITY_EN defined: array stores DATA_W+1 bits, even parity on write;
//    parity_err pulses with cpu_rvalid or with the str_ovalid beat on mismatch.
//  - Undefined: array DATA_W bits wide, parity_err tied 0 (port always present).
// STRUCTURE
//  - Package sector_buffer_pkg: FSM state encoding (IDLE, RD_STREAM, WR_STREAM, DONE),
//    DIR_RD/DIR_WR constants.
//  - Sub-module sector_ram_array: plain synchronous single-port array (we, addr, wdata,
//    registered rdata, width parameter); no reset; top holds FSM, pointer, skid, mux.
// TESTING
//  1 Host write 0xA5 @0x0010, read @0x0010 -> cpu_rvalid 1 cycle later, cpu_rdata=0xA5.
//  2 Preload 0..15 @0x1FF8, RD burst base 0x1FF8 len 16, oready=1 -> odata 0..15 in
//    order, addr wraps to 0x0000 after 0x1FFF, str_done one cycle after 16th beat.
//  3 RD burst len 8, oready toggled 1/0 each cycle -> no word lost/duplicated, odata
//    stable while oready=0, exactly 8 beats.
//  4 WR burst base 0x0100 len 4, ivalid gaps -> only handshaken words written;
//    host readback 0x0100..0x0103 matches.
//  5 str_start+cpu_en same cycle -> host held off until IDLE; abort after beat 3 of 10
//    -> IDLE next cycle, no str_done, cpu_ready=1; str_len=0 -> str_done next cycle.
//  6 PARITY_EN: force-flip array bit @0x0020, host read -> parity_err pulses with
//    cpu_rvalid; without macro parity_err stays 0; rst_n low mid-burst -> all reset.

Source files
------------

// File: rtl/sector_buffer_pkg.sv
// Shared types for the sector buffer RAM: burst FSM state encoding and stream direction codes.
package sector_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_STREAM = 2'd1,
        WR_STREAM = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic DIR_RD = 1'b1;
    localparam logic DIR_WR = 1'b0;

endpackage

// File: rtl/sector_ram_array.sv
// Plain synchronous single-port array with registered read data and no reset.
module sector_ram_array
    import sector_buffer_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    // Read-before-write: a write cycle returns the old word.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sector_buffer_ram.sv
// Sector buffer RAM: host random-access port plus auto-incrementing valid/ready burst port.
// Define SECTOR_RAM_PARITY_EN to store an even-parity bit per word and flag read mismatches.
module sector_buffer_ram
    import sector_buffer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_en,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              str_start,
    input  logic              str_dir,
    input  logic [ADDR_W-1:0] str_base,
    input  logic [ADDR_W:0]   str_len,
    input  logic              str_abort,
    output logic [DATA_W-1:0] str_odata,
    output logic              str_ovalid,
    input  logic              str_oready,
    input  logic [DATA_W-1:0] str_idata,
    input  logic              str_ivalid,
    output logic              str_iready,
    output logic              str_busy,
    output logic              str_done,
    output logic              parity_err
);

`ifdef SECTOR_RAM_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif
    localparam int CNT_W = ADDR_W + 1;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  ptr;
    logic [CNT_W-1:0]   len_q, issued, beats;
    logic               inflight, rd_pend;
    logic [RAM_W-1:0]   skid [2];
    logic               skid_wp, skid_rp;
    logic [1:0]         skid_cnt, occ;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  wdata_raw;
    logic [RAM_W-1:0]   ram_wdata, ram_rdata, head;
    logic               cpu_acc, start_acc, abort_act, issue, rd_beat, wr_beat, last_beat;
    logic               push, pop;

    assign cpu_ready  = (state == IDLE) && !str_start;
    assign cpu_acc    = cpu_en && cpu_ready;
    assign start_acc  = (state == IDLE) && str_start;
    assign str_busy   = (state == RD_STREAM) || (state == WR_STREAM);
    assign str_done   = (state == DONE);
    assign abort_act  = str_busy && str_abort;
    assign str_iready = (state == WR_STREAM);

    // Empty skid buffer bypasses the array output so a burst starts one cycle after issue.
    assign head       = (skid_cnt != 2'd0) ? skid[skid_rp] : ram_rdata;
    assign str_ovalid = (state == RD_STREAM) && ((skid_cnt != 2'd0) || inflight);
    assign str_odata  = str_ovalid ? head[DATA_W-1:0] : '0;
    assign rd_beat    = str_ovalid && str_oready;
    assign wr_beat    = str_ivalid && str_iready;
    assign last_beat  = (rd_beat || wr_beat) && ((beats + 1'b1) == len_q);

    assign occ   = skid_cnt + {1'b0, inflight};
    assign issue = (state == RD_STREAM) && (issued != len_q) &&
                   ((occ - {1'b0, rd_beat}) < 2'd2);
    assign push  = inflight && !((skid_cnt == 2'd0) && rd_beat);
    assign pop   = rd_beat && (skid_cnt != 2'd0);

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ptr;
        wdata_raw = str_idata;
        case (state)
            IDLE: begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_acc && !cpu_rw;
                wdata_raw = cpu_wdata;
            end
            WR_STREAM: ram_we = wr_beat;
            default: ;
        endcase
    end

`ifdef SECTOR_RAM_PARITY_EN
    assign ram_wdata = {^wdata_raw, wdata_raw};
`else
    assign ram_wdata = wdata_raw;
`endif

    sector_ram_array #(.WIDTH(RAM_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (str_start) begin
                if (str_len == '0)          state_nxt = DONE;
                else if (str_dir == DIR_RD) state_nxt = RD_STREAM;
                else                        state_nxt = WR_STREAM;
            end
            RD_STREAM, WR_STREAM: begin
                if (str_abort)      state_nxt = IDLE;
                else if (last_beat) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            len_q  <= '0;
            issued <= '0;
            beats  <= '0;
        end else if (start_acc) begin
            ptr    <= str_base;
            len_q  <= str_len;
            issued <= '0;
            beats  <= '0;
        end else begin
            if (issue || wr_beat)   ptr    <= ptr + 1'b1;
            if (issue)              issued <= issued + 1'b1;
            if (rd_beat || wr_beat) beats  <= beats + 1'b1;
        end
    end

    // Skid buffer and in-flight flag are discarded on abort or outside a read burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            skid_cnt <= '0;
            skid_wp  <= 1'b0;
            skid_rp  <= 1'b0;
            skid[0]  <= '0;
            skid[1]  <= '0;
        end else if (abort_act || (state != RD_STREAM)) begin
            inflight <= 1'b0;
            skid_cnt <= '0;
            skid_wp  <= 1'b0;
            skid_rp  <= 1'b0;
        end else begin
            inflight <= issue;
            if (push) begin
                skid[skid_wp] <= ram_rdata;
                skid_wp       <= ~skid_wp;
            end
            if (pop) skid_rp <= ~skid_rp;
            skid_cnt <= skid_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend    <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            rd_pend    <= cpu_acc && cpu_rw;
            cpu_rvalid <= rd_pend;
            if (rd_pend) cpu_rdata <= ram_rdata[DATA_W-1:0];
        end
    end

`ifdef SECTOR_RAM_PARITY_EN
    logic cpu_perr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cpu_perr <= 1'b0;
        else        cpu_perr <= rd_pend && (^ram_rdata);
    end
    assign parity_err = cpu_perr || (rd_beat && (^head));
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sector_buffer_ram.sv
// Directed bench for sector_buffer_ram with a memory model and read scoreboards (SECTOR_RAM_PARITY_EN aware).
module tb_sector_buffer_ram;
    import sector_buffer_pkg::*;

    localparam int DW = 8;
    localparam int AW = 13;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_en = 1'b0, cpu_rw = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          str_start = 1'b0, str_dir = 1'b0, str_abort = 1'b0;
    logic [AW-1:0] str_base = '0;
    logic [AW:0]   str_len = '0;
    logic [DW-1:0] str_odata;
    logic          str_ovalid;
    logic          str_oready = 1'b0;
    logic [DW-1:0] str_idata = '0;
    logic          str_ivalid = 1'b0;
    logic          str_iready, str_busy, str_done, parity_err;

    always #5 clk = ~clk;

    sector_buffer_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_en(cpu_en), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .str_start(str_start), .str_dir(str_dir), .str_base(str_base), .str_len(str_len),
        .str_abort(str_abort), .str_odata(str_odata), .str_ovalid(str_ovalid),
        .str_oready(str_oready), .str_idata(str_idata), .str_ivalid(str_ivalid),
        .str_iready(str_iready), .str_busy(str_busy), .str_done(str_done),
        .parity_err(parity_err)
    );

    int            tests = 0, fails = 0, cyc = 0;
    int            rd_beats = 0, wr_beats = 0, done_cnt = 0;
    int            first_beat_cyc = 0, last_beat_cyc = 0, done_cyc = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] cpu_q [$];
    logic [DW-1:0] str_q [$];
    logic [AW-1:0] wptr = '0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic          exp_perr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample/score everything before the edge, then release accepted one-shot requests.
    task automatic step();
        logic st_acc, c_acc;
        logic [AW-1:0] a;
        #1;
        st_acc = str_start && !str_busy && !str_done;
        c_acc  = cpu_en && cpu_ready;
        if (st_acc && str_dir == DIR_RD)
            for (int i = 0; i < int'(str_len); i++) begin
                a = str_base + AW'(i);
                str_q.push_back(model[a]);
            end
        if (st_acc && str_dir == DIR_WR) wptr = str_base;
        if (c_acc) begin
            if (cpu_rw) cpu_q.push_back(model[cpu_addr]);
            else        model[cpu_addr] = cpu_wdata;
        end
        if (stall_prev) chk("odata_stable", {24'b0, str_odata}, {24'b0, stall_data});
        stall_prev = str_ovalid && !str_oready && !str_abort;
        stall_data = str_odata;
        if (str_ovalid && str_oready) begin
            rd_beats++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            if (str_q.size() == 0) chk("rd_extra_beat", {31'b0, str_ovalid}, 0);
            else begin
                chk("str_odata", {24'b0, str_odata}, {24'b0, str_q.pop_front()});
                chk("str_perr", {31'b0, parity_err}, 0);
            end
        end
        if (str_ivalid && str_iready) begin
            model[wptr] = str_idata;
            wptr++;
            wr_beats++;
        end
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) chk("cpu_rvalid_spur", {31'b0, cpu_rvalid}, 0);
            else begin
                chk("cpu_rdata", {24'b0, cpu_rdata}, {24'b0, cpu_q.pop_front()});
                chk("cpu_perr", {31'b0, parity_err}, {31'b0, exp_perr});
            end
        end
        if (str_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (st_acc) str_start = 1'b0;
        if (c_acc)  cpu_en = 1'b0;
    endtask

    task automatic host_req(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        int n = 0;
        cpu_en = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = d;
        while (cpu_en && n < 40) begin step(); n++; end
        if (cpu_en) begin
            chk("host_accept", {31'b0, cpu_ready}, 1);
            cpu_en = 1'b0;
        end
        if (rw) begin step(); step(); end
    endtask

    task automatic start_burst(input logic dir, input logic [AW-1:0] base, input logic [AW:0] len);
        str_dir = dir; str_base = base; str_len = len; str_start = 1'b1;
        step();
        str_start = 1'b0;
    endtask

    // mode 0: oready held high; mode 1: oready toggles 1/0; mode 2: ivalid gap pattern
    task automatic wait_done(input int budget, input int mode);
        int d0 = done_cnt;
        int n = 0;
        logic [7:0] pat = 8'b1011_0010;
        while (done_cnt == d0 && n < budget) begin
            if (mode == 0) str_oready = 1'b1;
            if (mode == 1) str_oready = (n % 2 == 0);
            if (mode == 2) begin
                str_ivalid = pat[n % 8];
                str_idata  = 8'h30 + 8'(n);
            end
            step();
            n++;
        end
        str_ivalid = 1'b0;
        chk("burst_done", done_cnt - d0, 1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_cpu_ready"},  {31'b0, cpu_ready}, 1);
        chk({tag, "_cpu_rvalid"}, {31'b0, cpu_rvalid}, 0);
        chk({tag, "_cpu_rdata"},  {24'b0, cpu_rdata}, 0);
        chk({tag, "_busy"},       {31'b0, str_busy}, 0);
        chk({tag, "_done"},       {31'b0, str_done}, 0);
        chk({tag, "_ovalid"},     {31'b0, str_ovalid}, 0);
        chk({tag, "_odata"},      {24'b0, str_odata}, 0);
        chk({tag, "_iready"},     {31'b0, str_iready}, 0);
        chk({tag, "_perr"},       {31'b0, parity_err}, 0);
    endtask

    initial begin
        int r0, w0, d0;
        first_beat_cyc = -1;

        // Reset state
        #2;
        reset_checks("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: host write then read, latency and single-cycle pulse
        host_req(1'b0, 13'h0010, 8'hA5);
        cpu_en = 1'b1; cpu_rw = 1'b1; cpu_addr = 13'h0010;
        step();
        chk("rvalid_early", {31'b0, cpu_rvalid}, 0);
        step();
        chk("rvalid_lat1", {31'b0, cpu_rvalid}, 1);
        chk("rdata_a5", {24'b0, cpu_rdata}, 32'hA5);
        step();
        chk("rvalid_pulse", {31'b0, cpu_rvalid}, 0);
        chk("rdata_held", {24'b0, cpu_rdata}, 32'hA5);

        // 2: wrapping read burst at full rate
        for (int i = 0; i < 16; i++) host_req(1'b0, 13'h1FF8 + 13'(i), 8'(i));
        r0 = rd_beats; first_beat_cyc = -1;
        start_burst(DIR_RD, 13'h1FF8, 14'd16);
        wait_done(60, 0);
        chk("wrap_beats", rd_beats - r0, 16);
        chk("wrap_rate", last_beat_cyc - first_beat_cyc, 15);
        chk("wrap_done_lat", done_cyc - last_beat_cyc, 1);
        chk("wrap_q_empty", str_q.size(), 0);

        // 3: read burst with oready toggling
        r0 = rd_beats;
        start_burst(DIR_RD, 13'h1FFC, 14'd8);
        wait_done(80, 1);
        str_oready = 1'b0;
        chk("toggle_beats", rd_beats - r0, 8);
        chk("toggle_q_empty", str_q.size(), 0);

        // 4: write burst with ivalid gaps, then host readback
        w0 = wr_beats;
        start_burst(DIR_WR, 13'h0100, 14'd4);
        wait_done(60, 2);
        chk("wr_beats", wr_beats - w0, 4);
        chk("wr_model_0", {24'b0, model[13'h0100]}, 32'h31);
        chk("wr_model_3", {24'b0, model[13'h0103]}, 32'h37);
        for (int i = 0; i < 4; i++) host_req(1'b1, 13'h0100 + 13'(i), 8'h00);

        // 5a: stream start beats a simultaneous host request
        cpu_en = 1'b1; cpu_rw = 1'b1; cpu_addr = 13'h0010;
        str_dir = DIR_RD; str_base = 13'h1FF8; str_len = 14'd2; str_start = 1'b1;
        #1;
        chk("contend_ready", {31'b0, cpu_ready}, 0);
        step();
        str_start = 1'b0;
        wait_done(40, 0);
        chk("host_held", {31'b0, cpu_en}, 1);
        begin
            int n = 0;
            while (cpu_en && n < 10) begin step(); n++; end
        end
        chk("host_accepted", {31'b0, cpu_en}, 0);
        step(); step();

        // 5b: abort after third beat of ten
        r0 = rd_beats; d0 = done_cnt;
        str_oready = 1'b1;
        start_burst(DIR_RD, 13'h1FF8, 14'd10);
        begin
            int n = 0;
            while (rd_beats - r0 < 3 && n < 20) begin step(); n++; end
        end
        str_abort = 1'b1; str_oready = 1'b0;
        step();
        str_abort = 1'b0;
        chk("abort_busy", {31'b0, str_busy}, 0);
        chk("abort_ready", {31'b0, cpu_ready}, 1);
        chk("abort_ovalid", {31'b0, str_ovalid}, 0);
        step(); step(); step();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_beats", rd_beats - r0, 3);
        str_q.delete();

        // 5c: zero-length burst
        start_burst(DIR_RD, 13'h0000, 14'd0);
        chk("len0_done", {31'b0, str_done}, 1);
        step();
        chk("len0_idle_done", {31'b0, str_done}, 0);
        chk("len0_idle_ready", {31'b0, cpu_ready}, 1);

        // 6a: parity on host read
        host_req(1'b0, 13'h0020, 8'h5A);
`ifdef SECTOR_RAM_PARITY_EN
        dut.u_ram.mem[13'h0020][0] = ~dut.u_ram.mem[13'h0020][0];
        exp_perr = 1'b1;
`endif
        host_req(1'b1, 13'h0020, 8'h00);
        exp_perr = 1'b0;

        // 6b: reset in the middle of a stalled read burst
        str_oready = 1'b0;
        start_burst(DIR_RD, 13'h1FF8, 14'd16);
        step(); step(); step();
        chk("pre_rst_ovalid", {31'b0, str_ovalid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        stall_prev = 1'b0;
        str_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        host_req(1'b1, 13'h0010, 8'h00);

        chk("cpu_q_drained", cpu_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
